// File: rtl/zdos_pkg.sv
// Shared definitions for the z80-group DOS logic: trap FSM states, VG register
// indices and the default NMI stretch length.
package zdos_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NMI     = 2'd1,
    HANDLER = 2'd2,
    EXIT    = 2'd3
  } trap_state_e;

  localparam logic [1:0] VG_CMD = 2'd0;
  localparam logic [1:0] VG_TRK = 2'd1;
  localparam logic [1:0] VG_SEC = 2'd2;
  localparam logic [1:0] VG_DAT = 2'd3;

  localparam int NMI_LEN_DEF = 16;

endpackage

// File: rtl/trdemu_nmi_stretch.sv
// Stretches a one-cycle start strobe into an NMI request of exactly NMI_LEN
// fclk cycles; done flags the last high cycle so the FSM can advance with it.
module trdemu_nmi_stretch #(
  parameter int NMI_LEN = 16
) (
  input  logic fclk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic nmi_req,
  output logic done
);

  // Counts high cycles already spent, 1 on the first NMI cycle.
  logic [7:0] cnt;

  assign done = nmi_req && !abort && (cnt == 8'(NMI_LEN));

  // NOTE: reset is synchronous, so it lives inside the clocked block and
  // overrides everything else on the same edge.
  always_ff @(posedge fclk) begin
    if (rst || abort) begin
      nmi_req <= 1'b0;
      cnt     <= 8'd0;
    end else if (start) begin
      nmi_req <= 1'b1;
      cnt     <= 8'd1;
    end else if (done) begin
      nmi_req <= 1'b0;
      cnt     <= 8'd0;
    end else if (nmi_req) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/trdemu_trap_ctrl.sv
// VG93 software-emulation trap sequencer: captures a trapped VG access, fires
// a stretched NMI, maps emulation page #FE and write-protects it until exit.
module trdemu_trap_ctrl
  import zdos_pkg::*;
#(
  parameter int NMI_LEN = NMI_LEN_DEF,
  parameter int CNT_W   = 8
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             emu_en,
  input  logic             vg_rdwr_fclk,
  input  logic [1:0]       vg_a,
  input  logic             vg_wr,
  input  logic [7:0]       vg_wdata,
  input  logic [3:0]       fdd_mask,
  input  logic             dos,
  input  logic             romnram,
  input  logic             clr_nmi,
  input  logic             zpos,
  input  logic             m1_n,
  input  logic             clr_ovr,
  output logic             nmi_req,
  output logic             in_trdemu,
  output logic             trdemu_wr_disable,
  output logic [1:0]       trap_a,
  output logic             trap_wr,
  output logic [7:0]       trap_data,
  output logic             overrun,
  output logic [CNT_W-1:0] trap_cnt,
  output logic             busy
);

  trap_state_e state;
  logic        trap_hit;
  logic        accept;
  logic        in_nmi_or_handler;
  logic        nmi_abort;
  logic        nmi_done;

  assign trap_hit          = vg_rdwr_fclk & emu_en & fdd_mask[vg_a] & dos & romnram;
  assign in_nmi_or_handler = (state == NMI) || (state == HANDLER);
  // A new trap is only taken when no handler owns the emulation page.
  assign accept            = trap_hit && ((state == IDLE) || (state == EXIT));
  assign nmi_abort         = (state == NMI) && clr_nmi;
  assign busy              = (state != IDLE);

  trdemu_nmi_stretch #(
    .NMI_LEN (NMI_LEN)
  ) u_nmi_stretch (
    .fclk    (fclk),
    .rst     (rst),
    .start   (accept),
    .abort   (nmi_abort),
    .nmi_req (nmi_req),
    .done    (nmi_done)
  );

  always_ff @(posedge fclk) begin
    if (rst) begin
      state             <= IDLE;
      in_trdemu         <= 1'b0;
      trdemu_wr_disable <= 1'b0;
      trap_a            <= 2'd0;
      trap_wr           <= 1'b0;
      trap_data         <= 8'd0;
      overrun           <= 1'b0;
      trap_cnt          <= '0;
    end else begin
      if (trap_hit && in_nmi_or_handler) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end

      if (accept) begin
        trap_a            <= vg_a;
        trap_wr           <= vg_wr;
        trap_cnt          <= trap_cnt + 1'b1;
        in_trdemu         <= 1'b1;
        trdemu_wr_disable <= 1'b1;
        state             <= NMI;
        // Reads keep the last written byte so the handler still sees it.
        if (vg_wr) begin
          trap_data <= vg_wdata;
        end
      end else begin
        case (state)
          NMI: begin
            if (clr_nmi) begin
              state     <= EXIT;
              in_trdemu <= 1'b0;
            end else if (nmi_done) begin
              state <= HANDLER;
            end
          end
          HANDLER: begin
            if (clr_nmi) begin
              state     <= EXIT;
              in_trdemu <= 1'b0;
            end
          end
          EXIT: begin
            if (zpos && !m1_n) begin
              state             <= IDLE;
              trdemu_wr_disable <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trdemu_trap_ctrl.sv
// Self-checking bench for trdemu_trap_ctrl: directed scenarios plus a random
// run, all judged against a phase/countdown model of the trap sequence.
module tb_trdemu_trap_ctrl;

  localparam int NMI_LEN = 16;
  localparam int CNT_W   = 8;

  localparam int P_IDLE = 0;
  localparam int P_NMI  = 1;
  localparam int P_HND  = 2;
  localparam int P_EXIT = 3;

  logic             fclk = 1'b0;
  logic             rst = 1'b1;
  logic             emu_en = 1'b0;
  logic             vg_rdwr_fclk = 1'b0;
  logic [1:0]       vg_a = 2'd0;
  logic             vg_wr = 1'b0;
  logic [7:0]       vg_wdata = 8'd0;
  logic [3:0]       fdd_mask = 4'd0;
  logic             dos = 1'b0;
  logic             romnram = 1'b0;
  logic             clr_nmi = 1'b0;
  logic             zpos = 1'b0;
  logic             m1_n = 1'b1;
  logic             clr_ovr = 1'b0;
  logic             nmi_req;
  logic             in_trdemu;
  logic             trdemu_wr_disable;
  logic [1:0]       trap_a;
  logic             trap_wr;
  logic [7:0]       trap_data;
  logic             overrun;
  logic [CNT_W-1:0] trap_cnt;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which phase the sequence is in and how many NMI cycles remain.
  int       m_phase = P_IDLE;
  int       m_left  = 0;
  bit       m_in, m_wrd, m_wr, m_ovr;
  bit [1:0] m_a;
  bit [7:0] m_data;
  int       m_cnt = 0;

  trdemu_trap_ctrl #(
    .NMI_LEN (NMI_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .fclk              (fclk),
    .rst               (rst),
    .emu_en            (emu_en),
    .vg_rdwr_fclk      (vg_rdwr_fclk),
    .vg_a              (vg_a),
    .vg_wr             (vg_wr),
    .vg_wdata          (vg_wdata),
    .fdd_mask          (fdd_mask),
    .dos               (dos),
    .romnram           (romnram),
    .clr_nmi           (clr_nmi),
    .zpos              (zpos),
    .m1_n              (m1_n),
    .clr_ovr           (clr_ovr),
    .nmi_req           (nmi_req),
    .in_trdemu         (in_trdemu),
    .trdemu_wr_disable (trdemu_wr_disable),
    .trap_a            (trap_a),
    .trap_wr           (trap_wr),
    .trap_data         (trap_data),
    .overrun           (overrun),
    .trap_cnt          (trap_cnt),
    .busy              (busy)
  );

  always #5 fclk = ~fclk;

  function automatic logic [23:0] dut_vec();
    return {nmi_req, in_trdemu, trdemu_wr_disable, trap_a, trap_wr, trap_data,
            overrun, trap_cnt, busy};
  endfunction

  function automatic logic [23:0] model_vec();
    logic [7:0] c;
    c = 8'(m_cnt);
    return {(m_left > 0), m_in, m_wrd, m_a, m_wr, m_data, m_ovr, c, (m_phase != P_IDLE)};
  endfunction

  // Advance the model with the inputs currently applied, clock once, then
  // release the one-cycle strobes.
  task automatic step();
    bit hit;
    hit = vg_rdwr_fclk && emu_en && fdd_mask[vg_a] && dos && romnram;
    if (rst) begin
      m_phase = P_IDLE; m_left = 0; m_in = 0; m_wrd = 0; m_wr = 0;
      m_ovr = 0; m_a = 0; m_data = 0; m_cnt = 0;
    end else begin
      if (hit && (m_phase == P_NMI || m_phase == P_HND)) m_ovr = 1;
      else if (clr_ovr) m_ovr = 0;
      if (hit && (m_phase == P_IDLE || m_phase == P_EXIT)) begin
        m_a = vg_a; m_wr = vg_wr;
        if (vg_wr) m_data = vg_wdata;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_in = 1; m_wrd = 1; m_phase = P_NMI; m_left = NMI_LEN;
      end else begin
        case (m_phase)
          P_NMI: begin
            if (clr_nmi) begin
              m_phase = P_EXIT; m_left = 0; m_in = 0;
            end else begin
              m_left--;
              if (m_left == 0) m_phase = P_HND;
            end
          end
          P_HND: if (clr_nmi) begin m_phase = P_EXIT; m_in = 0; end
          P_EXIT: if (zpos && !m1_n) begin m_phase = P_IDLE; m_wrd = 0; end
          default: ;
        endcase
      end
    end
    @(posedge fclk);
    #1;
    rst = 0; vg_rdwr_fclk = 0; clr_nmi = 0; clr_ovr = 0; zpos = 0; m1_n = 1;
  endtask

  task automatic set_env(input bit en, input bit [3:0] mask, input bit d, input bit rom);
    emu_en = en; fdd_mask = mask; dos = d; romnram = rom;
  endtask

  task automatic access(input bit [1:0] a, input bit wr, input bit [7:0] data);
    vg_rdwr_fclk = 1; vg_a = a; vg_wr = wr; vg_wdata = data;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    n_tests++;
    if (dut_vec() !== 24'h0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp %h", dut_vec(), 24'h0);
    end
    n_tests++;
    if (model_vec() !== 24'h0) begin
      n_fail++; $display("FAIL reset_model got %h exp %h", model_vec(), 24'h0);
    end
  endtask

  task automatic test_basic_trap();
    int len;
    set_env(1, 4'b0100, 1, 1);
    access(2'd2, 1, 8'h5A);
    step();
    n_tests++;
    if ({nmi_req, in_trdemu, trdemu_wr_disable, trap_a, trap_wr, trap_data, trap_cnt}
        !== {1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 8'h5A, 8'd1}) begin
      n_fail++;
      $display("FAIL basic_capture got nmi=%b in=%b wrd=%b a=%0d wr=%b d=%h cnt=%0d exp 1 1 1 2 1 5a 1",
               nmi_req, in_trdemu, trdemu_wr_disable, trap_a, trap_wr, trap_data, trap_cnt);
    end
    len = 0;
    while (nmi_req === 1'b1 && len < 40) begin
      len++;
      step();
    end
    n_tests++;
    if (len != NMI_LEN) begin
      n_fail++; $display("FAIL nmi_pulse_len got %0d exp %0d", len, NMI_LEN);
    end
    n_tests++;
    if ({in_trdemu, busy, trdemu_wr_disable} !== 3'b111) begin
      n_fail++; $display("FAIL handler_state got in=%b busy=%b wrd=%b exp 1 1 1",
                         in_trdemu, busy, trdemu_wr_disable);
    end
    clr_nmi = 1;
    step();
    n_tests++;
    if ({in_trdemu, trdemu_wr_disable, busy} !== 3'b011) begin
      n_fail++; $display("FAIL exit_entry got in=%b wrd=%b busy=%b exp 0 1 1",
                         in_trdemu, trdemu_wr_disable, busy);
    end
    for (int i = 0; i < 5; i++) begin
      zpos = 1; m1_n = 1;
      step();
      n_tests++;
      if (trdemu_wr_disable !== 1'b1) begin
        n_fail++; $display("FAIL exit_no_m1 cycle %0d got wrd=%b exp 1", i, trdemu_wr_disable);
      end
    end
    zpos = 1; m1_n = 0;
    step();
    n_tests++;
    if ({trdemu_wr_disable, busy} !== 2'b00) begin
      n_fail++; $display("FAIL exit_m1_fetch got wrd=%b busy=%b exp 0 0", trdemu_wr_disable, busy);
    end
  endtask

  task automatic test_gating();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_env(1, 4'b1011, 1, 1);
        1: set_env(1, 4'b0100, 0, 1);
        2: set_env(1, 4'b0100, 1, 0);
        default: set_env(0, 4'b1111, 1, 1);
      endcase
      access(2'd2, 1, 8'h33);
      step();
      n_tests++;
      if (busy !== 1'b0 || dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL gating_%0d got %h exp %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_overrun();
    set_env(1, 4'b1111, 1, 1);
    access(2'd1, 1, 8'hC3);
    step();
    for (int i = 0; i < NMI_LEN; i++) step();
    access(2'd3, 1, 8'h7E);
    step();
    n_tests++;
    if ({overrun, trap_a, trap_data, trap_cnt} !== {1'b1, 2'd1, 8'hC3, 8'd2}) begin
      n_fail++; $display("FAIL overrun_set got ovr=%b a=%0d d=%h cnt=%0d exp 1 1 c3 2",
                         overrun, trap_a, trap_data, trap_cnt);
    end
    access(2'd0, 1, 8'h01);
    clr_ovr = 1;
    step();
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set_wins got %b exp 1", overrun);
    end
    clr_ovr = 1;
    step();
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear got %b exp 0", overrun);
    end
    access(2'd2, 0, 8'h00);
    clr_nmi = 1;
    step();
    n_tests++;
    if ({overrun, in_trdemu, busy, trap_cnt} !== {1'b1, 1'b0, 1'b1, 8'd2}) begin
      n_fail++; $display("FAIL clr_nmi_beats_trap got ovr=%b in=%b busy=%b cnt=%0d exp 1 0 1 2",
                         overrun, in_trdemu, busy, trap_cnt);
    end
    zpos = 1; m1_n = 0; clr_ovr = 1;
    step();
  endtask

  task automatic test_early_exit();
    set_env(1, 4'b1111, 1, 1);
    access(2'd0, 0, 8'hEE);
    step();
    n_tests++;
    if ({trap_a, trap_wr, trap_data} !== {2'd0, 1'b0, 8'hC3}) begin
      n_fail++; $display("FAIL read_holds_data got a=%0d wr=%b d=%h exp 0 0 c3",
                         trap_a, trap_wr, trap_data);
    end
    step();
    step();
    clr_nmi = 1;
    step();
    n_tests++;
    if ({nmi_req, in_trdemu, trdemu_wr_disable, busy} !== 4'b0011) begin
      n_fail++; $display("FAIL early_exit got nmi=%b in=%b wrd=%b busy=%b exp 0 0 1 1",
                         nmi_req, in_trdemu, trdemu_wr_disable, busy);
    end
    access(2'd1, 1, 8'h11);
    zpos = 1; m1_n = 0;
    step();
    n_tests++;
    if ({nmi_req, in_trdemu, trap_data, trap_cnt} !== {1'b1, 1'b1, 8'h11, 8'd4}) begin
      n_fail++; $display("FAIL exit_retrap got nmi=%b in=%b d=%h cnt=%0d exp 1 1 11 4",
                         nmi_req, in_trdemu, trap_data, trap_cnt);
    end
    for (int i = 0; i < NMI_LEN; i++) step();
    clr_nmi = 1;
    step();
    zpos = 1; m1_n = 0;
    step();
  endtask

  task automatic test_rst_mid_nmi();
    access(2'd3, 1, 8'h99);
    step();
    for (int i = 0; i < 7; i++) step();
    n_tests++;
    if (nmi_req !== 1'b1) begin
      n_fail++; $display("FAIL nmi_before_rst got %b exp 1", nmi_req);
    end
    rst = 1;
    step();
    n_tests++;
    if (dut_vec() !== 24'h0) begin
      n_fail++; $display("FAIL rst_mid_nmi got %h exp %h", dut_vec(), 24'h0);
    end
  endtask

  task automatic test_cnt_wrap();
    set_env(1, 4'b1111, 1, 1);
    for (int i = 0; i < 256; i++) begin
      access(2'(i), 1, 8'(i));
      step();
      if (i == 254) begin
        n_tests++;
        if (trap_cnt !== 8'd255) begin
          n_fail++; $display("FAIL cnt_255 got %0d exp 255", trap_cnt);
        end
      end
      clr_nmi = 1;
      step();
    end
    n_tests++;
    if ({trap_cnt, trap_data} !== {8'd0, 8'hFF}) begin
      n_fail++; $display("FAIL cnt_wrap got cnt=%0d d=%h exp 0 ff", trap_cnt, trap_data);
    end
    zpos = 1; m1_n = 0;
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      emu_en       = ($urandom_range(0, 9) != 0);
      fdd_mask     = 4'($urandom);
      dos          = ($urandom_range(0, 9) != 0);
      romnram      = ($urandom_range(0, 9) != 0);
      vg_rdwr_fclk = ($urandom_range(0, 99) < 15);
      vg_a         = 2'($urandom);
      vg_wr        = 1'($urandom);
      vg_wdata     = 8'($urandom);
      clr_nmi      = ($urandom_range(0, 99) < 5);
      zpos         = ($urandom_range(0, 99) < 30);
      m1_n         = 1'($urandom);
      clr_ovr      = ($urandom_range(0, 99) < 5);
      step();
      n_tests++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random cycle %0d got %h exp %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_trap();
    test_gating();
    test_overrun();
    test_early_exit();
    test_rst_mid_nmi();
    test_cnt_wrap();
    rst = 1;
    step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
